osd_label_writer: RTL

Fills the 1-bit OSD label bitmap RAM (144 x 28 pixels, row-major, address 0..4031) with the rendered name of the recognised fruit class. It is the write side of the label RAM whose read side drives the label overlay above the detection box. On a new class result it waits for the vertical-sync rising edge, then renders up to 9 glyphs of 16 x 28 pixels from an external font ROM, one pixel per cycle.

---
 rtl/osd_label_writer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/osd_label_writer.sv
// rtl/osd_label_writer.sv - renders the recognised fruit class name into the 1-bit OSD label bitmap RAM
//
// Ports:
//   pixelclk     sole clock, rising edge
//   reset        synchronous active-high reset
//   i_vsync      vertical sync (active high); rendering starts on its rising edge
//   class_id     recognised class 0..7, qualified by class_valid (one-cycle strobe)
//   font_addr    font ROM address = char_code*28 + row (registered)
//   font_data    font ROM row, bit 15 = leftmost pixel, valid one cycle after font_addr
//   osd_wr_en    bitmap RAM write enable
//   osd_wr_addr  bitmap RAM write address, row*144 + char*16 + bit
//   osd_wr_data  pixel value
//   busy         high whenever the writer is not idle
//   done         one-cycle pulse after the last pixel of a label
//
// Optional feature: OSD_WR_UNDERLINE_EN forces the bottom glyph row to all ones.

module osd_label_writer #(
   parameter int OSD_WIDTH  = 144,
   parameter int OSD_HEIGHT = 28,
   parameter int GLYPHS     = 9
) (
   input  logic        pixelclk,
   input  logic        reset,
   input  logic        i_vsync,
   input  logic [2:0]  class_id,
   input  logic        class_valid,
   output logic [10:0] font_addr,
   input  logic [15:0] font_data,
   output logic        osd_wr_en,
   output logic [15:0] osd_wr_addr,
   output logic        osd_wr_data,
   output logic        busy,
   output logic        done
);

   localparam int PIXELS = OSD_WIDTH * OSD_HEIGHT;

   typedef enum logic [2:0] {IDLE, ARM, FETCH, WAIT, LOAD, WRITE, FINISH} state_t;

   state_t      state_q, state_d;
   logic        vs_d0, vs_d1, vs_rise;
   logic [2:0]  cur_class, target_q, pend_class;
   logic        pend_valid;
   logic [4:0]  row_q;
   logic [3:0]  char_q, bit_q;
   logic [15:0] wr_cnt_q, shift_q;
   logic [71:0] name_w;
   logic [7:0]  ascii_w;
   logic [5:0]  code_w;

   // Names are stored as ASCII, leftmost character in the top byte, space padded.
   function automatic logic [71:0] name_of(input logic [2:0] cls);
      case (cls)
         3'd1:    name_of = "APPLE    ";
         3'd2:    name_of = "BANANA   ";
         3'd3:    name_of = "ORANGE   ";
         3'd4:    name_of = "PEAR     ";
         3'd5:    name_of = "GRAPE    ";
         3'd6:    name_of = "MANGO    ";
         3'd7:    name_of = "UNKNOWN  ";
         default: name_of = "         ";
      endcase
   endfunction

   assign vs_rise = vs_d0 & ~vs_d1;

   always_comb begin
      name_w  = name_of(target_q);
      ascii_w = 8'(name_w >> (8 * (GLYPHS - 1 - int'(char_q))));
      code_w  = 6'(ascii_w - 8'h20);
   end

   always_ff @(posedge pixelclk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      osd_wr_en   = 1'b0;
      osd_wr_addr = 16'd0;
      osd_wr_data = 1'b0;
      busy        = (state_q != IDLE);
      done        = 1'b0;
      case (state_q)
         IDLE:   if (class_valid && class_id != cur_class) state_d = ARM;
         ARM:    if (vs_rise) state_d = FETCH;
         FETCH:  state_d = WAIT;
         WAIT:   state_d = LOAD;
         LOAD:   state_d = WRITE;
         WRITE: begin
            osd_wr_en   = 1'b1;
            osd_wr_addr = wr_cnt_q;
            osd_wr_data = shift_q[15];
            if (&bit_q) state_d = (wr_cnt_q == 16'(PIXELS - 1)) ? FINISH : FETCH;
         end
         FINISH: begin
            done    = 1'b1;
            state_d = pend_valid ? ARM : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pixelclk) begin
      if (reset) begin
         vs_d0      <= 1'b0;
         vs_d1      <= 1'b0;
         cur_class  <= 3'd0;
         target_q   <= 3'd0;
         pend_class <= 3'd0;
         pend_valid <= 1'b0;
         row_q      <= 5'd0;
         char_q     <= 4'd0;
         bit_q      <= 4'd0;
         wr_cnt_q   <= 16'd0;
         shift_q    <= 16'd0;
         font_addr  <= 11'd0;
      end else begin
         vs_d0 <= i_vsync;
         vs_d1 <= vs_d0;
         case (state_q)
            IDLE: if (class_valid && class_id != cur_class) target_q <= class_id;
            ARM: if (vs_rise) begin
               row_q    <= 5'd0;
               char_q   <= 4'd0;
               wr_cnt_q <= 16'd0;
            end
            FETCH: font_addr <= {5'd0, code_w} * 11'd28 + {6'd0, row_q};
            LOAD: begin
`ifdef OSD_WR_UNDERLINE_EN
               shift_q <= (row_q == 5'(OSD_HEIGHT - 1)) ? 16'hFFFF : font_data;
`else
               shift_q <= font_data;
`endif
               bit_q <= 4'd0;
            end
            WRITE: begin
               shift_q  <= {shift_q[14:0], 1'b0};
               wr_cnt_q <= wr_cnt_q + 16'd1;
               bit_q    <= bit_q + 4'd1;
               if (&bit_q) begin
                  if (char_q == 4'(GLYPHS - 1)) begin
                     char_q <= 4'd0;
                     row_q  <= row_q + 5'd1;
                  end else begin
                     char_q <= char_q + 4'd1;
                  end
               end
            end
            FINISH: begin
               cur_class <= target_q;
               if (pend_valid) begin
                  target_q   <= pend_class;
                  pend_valid <= 1'b0;
               end
            end
            default: ;
         endcase
         // A newer class while busy replaces any pending one; re-requesting the
         // class being drawn cancels it.
         if (state_q != IDLE && class_valid) begin
            if (class_id != target_q) begin
               pend_class <= class_id;
               pend_valid <= 1'b1;
            end else begin
               pend_valid <= 1'b0;
            end
         end
      end
   end

endmodule
